// File: rtl/if_issue_if.sv
// Bus between the fetch/issue stage and its environment: instruction memory,
// redirect input, and the issued instruction with its load-forward tags.
interface if_issue_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      imem_addr;
   logic [31:0]      imem_data;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [31:0]      instr_out;
   logic [2:0]       ld_rs_out;
   logic [2:0]       ld_rt_out;
   logic             hazard_stall;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output imem_addr, instr_out, ld_rs_out, ld_rt_out, hazard_stall, bubble_cnt,
      input  imem_data, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, instr_out, ld_rs_out, ld_rt_out, hazard_stall, bubble_cnt,
      output imem_data, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/if_issue.sv
// Fetch/issue stage: owns the PC, injects one bubble per load-use hazard against
// the last issued LDW, tags issued instructions with load-forward codes.
module if_issue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter int          CNT_W    = 16
) (
   input  logic          clk,
   input  logic          rst,
   if_issue_if.master    bus
);
   localparam logic [5:0]  OP_STALL   = 6'h00;
   localparam logic [5:0]  OP_RTYPE   = 6'h01;
   localparam logic [5:0]  OP_LDW     = 6'h02;
   localparam logic [5:0]  OP_SDW     = 6'h03;
   localparam logic [5:0]  OP_BEQ     = 6'h04;
   localparam logic [31:0] STALL_WORD = {OP_STALL, 26'd0};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [2:0]       ld_rs_q, ld_rs_d;
   logic [2:0]       ld_rt_q, ld_rt_d;
   logic             prev_vld_q, prev_vld_d;
   logic [4:0]       prev_reg_q, prev_reg_d;
   logic             pprev_vld_q;
   logic [4:0]       pprev_reg_q;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic             stall;

   logic [5:0] op;
   logic [4:0] rs, rt, dst;
   logic       use_rs, use_rt, is_ldw, hazard;

   always_comb begin
      op     = bus.imem_data[31:26];
      rs     = bus.imem_data[20:16];
      dst    = bus.imem_data[25:21];
      rt     = ((op == OP_SDW) || (op == OP_BEQ)) ? bus.imem_data[25:21] : bus.imem_data[15:11];
      is_ldw = (op == OP_LDW);
      use_rs = is_ldw || (op == OP_SDW) || (op == OP_BEQ) || (op == OP_RTYPE);
      use_rt = (op == OP_SDW) || (op == OP_BEQ) || (op == OP_RTYPE);
      // prev_vld_q already excludes R0 destinations, so no separate R0 guard here
      hazard = prev_vld_q && ((use_rs && (rs == prev_reg_q)) || (use_rt && (rt == prev_reg_q)));
   end

   always_comb begin
      pc_d       = pc_q + PC_STEP;
      instr_d    = bus.imem_data;
      ld_rs_d    = {2'b00, use_rs && pprev_vld_q && (rs == pprev_reg_q)};
      ld_rt_d    = {2'b00, use_rt && pprev_vld_q && (rt == pprev_reg_q)};
      prev_vld_d = is_ldw && (dst != 5'd0);
      prev_reg_d = prev_vld_d ? dst : 5'd0;
      bcnt_d     = bcnt_q;
      stall      = 1'b0;
      if (bus.redirect_valid) begin
         pc_d       = bus.redirect_pc;
         instr_d    = STALL_WORD;
         ld_rs_d    = 3'd0;
         ld_rt_d    = 3'd0;
         prev_vld_d = 1'b0;
         prev_reg_d = 5'd0;
      end else if (hazard) begin
         pc_d       = pc_q;
         instr_d    = STALL_WORD;
         ld_rs_d    = 3'd0;
         ld_rt_d    = 3'd0;
         prev_vld_d = 1'b0;
         prev_reg_d = 5'd0;
         bcnt_d     = sat_inc(bcnt_q);
         stall      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         instr_q     <= STALL_WORD;
         ld_rs_q     <= 3'd0;
         ld_rt_q     <= 3'd0;
         prev_vld_q  <= 1'b0;
         prev_reg_q  <= 5'd0;
         pprev_vld_q <= 1'b0;
         pprev_reg_q <= 5'd0;
         bcnt_q      <= '0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         ld_rs_q     <= ld_rs_d;
         ld_rt_q     <= ld_rt_d;
         pprev_vld_q <= prev_vld_q;
         pprev_reg_q <= prev_reg_q;
         prev_vld_q  <= prev_vld_d;
         prev_reg_q  <= prev_reg_d;
         bcnt_q      <= bcnt_d;
      end
   end

   // A reset in progress suppresses the bubble indication; the edge reloads everything anyway
   assign bus.hazard_stall = stall && !rst;
   assign bus.imem_addr    = pc_q;
   assign bus.instr_out    = instr_q;
   assign bus.ld_rs_out    = ld_rs_q;
   assign bus.ld_rt_out    = ld_rt_q;
   assign bus.bubble_cnt   = bcnt_q;
endmodule
